// File: rtl/color_pkg.sv
// Shared widths, colour-code constants and flash FSM states for the pixel colour path.
package color_pkg;

  localparam int CODE_W = 6;

  localparam logic [CODE_W-1:0] WHITE      = 6'd0;
  localparam logic [CODE_W-1:0] BLACK      = 6'd1;
  localparam logic [CODE_W-1:0] GREEN      = 6'd2;
  localparam logic [CODE_W-1:0] RED        = 6'd3;
  localparam logic [CODE_W-1:0] LIGHT_BLUE = 6'd4;
  localparam logic [CODE_W-1:0] YELLOW     = 6'd5;
  localparam logic [CODE_W-1:0] GREY       = 6'd6;
  localparam logic [CODE_W-1:0] ORANGE     = 6'd7;
  localparam logic [CODE_W-1:0] BROWN      = 6'd8;
  localparam logic [CODE_W-1:0] PURPLE     = 6'd9;
  localparam logic [CODE_W-1:0] DARK_BLUE  = 6'd10;

  typedef enum logic {
    IDLE  = 1'b0,
    FLASH = 1'b1
  } flash_state_e;

endpackage

// File: rtl/layer_priority_sel.sv
// Fixed-priority layer select: the lowest-index requesting layer wins and its code is passed out.
module layer_priority_sel
  import color_pkg::*;
#(
  parameter int NUM_LAYERS = 4
) (
  input  logic [NUM_LAYERS-1:0]        i_req,
  input  logic [NUM_LAYERS*CODE_W-1:0] i_codes,
  output logic                         o_hit,
  output logic [CODE_W-1:0]            o_code
);

  // Walk from the lowest priority upward so the last assignment is the winner.
  always_comb begin
    o_hit  = 1'b0;
    o_code = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_hit  = 1'b1;
        o_code = i_codes[i*CODE_W +: CODE_W];
      end
    end
  end

endmodule

// File: rtl/color_layer_arbiter.sv
// Per-pixel layer arbiter with frame-counted red/white hit flash on layer 0.
// Optional per-layer enable mask: define COLOR_ARB_LAYER_MASK_EN.
module color_layer_arbiter
  import color_pkg::*;
#(
  parameter int NUM_LAYERS   = 4,
  parameter int FLASH_FRAMES = 30,
  parameter int FLASH_PERIOD = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_frame_start,
  input  logic                         i_pix_valid,
  input  logic [NUM_LAYERS-1:0]        i_layer_req,
  input  logic [NUM_LAYERS*CODE_W-1:0] i_layer_code,
  input  logic [CODE_W-1:0]            i_bg_code,
  input  logic                         i_flash_trig,
`ifdef COLOR_ARB_LAYER_MASK_EN
  input  logic                         i_cfg_we,
  input  logic [NUM_LAYERS-1:0]        i_cfg_mask,
`endif
  output logic                         o_pix_valid_out,
  output logic [CODE_W-1:0]            o_colorcode,
  output logic                         o_flash_busy
);

  localparam int               CNT_W    = $clog2(FLASH_FRAMES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FLASH_FRAMES);
  localparam logic [CNT_W-1:0] PERIOD   = CNT_W'(FLASH_PERIOD);

  flash_state_e          r_state;
  flash_state_e          w_state_nxt;
  logic [CNT_W-1:0]      r_frame_cnt;
  logic [CNT_W-1:0]      w_frame_cnt_nxt;
  logic [CNT_W-1:0]      w_frame_cnt_inc;
  logic                  r_phase;
  logic                  w_phase_nxt;

  logic [NUM_LAYERS-1:0] w_layer_en;
  logic [NUM_LAYERS-1:0] w_layer_req_eff;
  logic                  w_sel_hit;
  logic [CODE_W-1:0]     w_sel_code;
  logic [CODE_W-1:0]     w_code_nxt;

  logic                  r_pix_valid_out;
  logic [CODE_W-1:0]     r_colorcode;
  logic                  r_flash_busy;

`ifdef COLOR_ARB_LAYER_MASK_EN
  logic [NUM_LAYERS-1:0] r_layer_en;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_layer_en <= '1;
    end else if (i_cfg_we) begin
      r_layer_en <= i_cfg_mask;
    end
  end

  assign w_layer_en = r_layer_en;
`else
  assign w_layer_en = '1;
`endif

  assign w_layer_req_eff = i_layer_req & w_layer_en;

  layer_priority_sel #(
    .NUM_LAYERS(NUM_LAYERS)
  ) u_sel (
    .i_req   (w_layer_req_eff),
    .i_codes (i_layer_code),
    .o_hit   (w_sel_hit),
    .o_code  (w_sel_code)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_frame_cnt <= '0;
      r_phase     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
      r_phase     <= w_phase_nxt;
    end
  end

  // A trigger always restarts the flash, so it outranks a same-cycle frame_start.
  always_comb begin
    w_state_nxt     = r_state;
    w_frame_cnt_nxt = r_frame_cnt;
    w_phase_nxt     = r_phase;
    w_frame_cnt_inc = r_frame_cnt + CNT_W'(1);
    if (i_flash_trig) begin
      w_state_nxt     = FLASH;
      w_frame_cnt_nxt = '0;
      w_phase_nxt     = 1'b0;
    end else if ((r_state == FLASH) && i_frame_start) begin
      if (w_frame_cnt_inc == LAST_CNT) begin
        w_state_nxt     = IDLE;
        w_frame_cnt_nxt = '0;
        w_phase_nxt     = 1'b0;
      end else begin
        w_frame_cnt_nxt = w_frame_cnt_inc;
        if ((w_frame_cnt_inc % PERIOD) == '0) begin
          w_phase_nxt = ~r_phase;
        end
      end
    end
  end

  always_comb begin
    w_code_nxt = BLACK;
    if (i_pix_valid) begin
      if ((r_state == FLASH) && w_layer_req_eff[0]) begin
        w_code_nxt = r_phase ? WHITE : RED;
      end else if (w_sel_hit) begin
        w_code_nxt = w_sel_code;
      end else begin
        w_code_nxt = i_bg_code;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pix_valid_out <= 1'b0;
      r_colorcode     <= BLACK;
      r_flash_busy    <= 1'b0;
    end else begin
      r_pix_valid_out <= i_pix_valid;
      r_colorcode     <= w_code_nxt;
      r_flash_busy    <= (w_state_nxt == FLASH);
    end
  end

  assign o_pix_valid_out = r_pix_valid_out;
  assign o_colorcode     = r_colorcode;
  assign o_flash_busy    = r_flash_busy;

endmodule

// File: tb/tb_color_layer_arbiter.sv
// Self-checking bench for color_layer_arbiter: frame-level flash model plus directed literal checks.
module tb_color_layer_arbiter;
  import color_pkg::*;

  localparam int NUM_LAYERS   = 4;
  localparam int FLASH_FRAMES = 30;
  localparam int FLASH_PERIOD = 4;

  logic        clock      = 1'b0;
  logic        resetN     = 1'b0;
  logic        frameStart = 1'b0;
  logic        pixValid   = 1'b0;
  logic        flashTrig  = 1'b0;
  logic [3:0]  layerReq   = '0;
  logic [23:0] layerCode  = '0;
  logic [5:0]  bgCode     = '0;
  logic        pixValidOut;
  logic [5:0]  colorCode;
  logic        flashBusy;

  int checks   = 0;
  int failures = 0;

  bit         modelFlashing = 1'b0;
  int         modelFrames   = 0;
  logic [5:0] expCode       = BLACK;
  logic       expValid      = 1'b0;
  logic       expBusy       = 1'b0;

  color_layer_arbiter #(
    .NUM_LAYERS  (NUM_LAYERS),
    .FLASH_FRAMES(FLASH_FRAMES),
    .FLASH_PERIOD(FLASH_PERIOD)
  ) dut (
    .i_clk          (clock),
    .i_rst_n        (resetN),
    .i_frame_start  (frameStart),
    .i_pix_valid    (pixValid),
    .i_layer_req    (layerReq),
    .i_layer_code   (layerCode),
    .i_bg_code      (bgCode),
    .i_flash_trig   (flashTrig),
    .o_pix_valid_out(pixValidOut),
    .o_colorcode    (colorCode),
    .o_flash_busy   (flashBusy)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // The flash phase follows from how many whole periods of frames have elapsed since the trigger.
  function automatic logic [5:0] modelCode(input logic pv, input logic [3:0] req, input logic [23:0] codes,
                                           input logic [5:0] bg, input bit flashing, input int frames);
    if (!pv) return BLACK;
    if (flashing && req[0]) return (((frames / FLASH_PERIOD) % 2) == 0) ? RED : WHITE;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (req[i]) return codes[i*6 +: 6];
    end
    return bg;
  endfunction

  always @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      modelFlashing = 1'b0;
      modelFrames   = 0;
      expCode       = BLACK;
      expValid      = 1'b0;
      expBusy       = 1'b0;
    end else begin
      expValid = pixValid;
      expCode  = modelCode(pixValid, layerReq, layerCode, bgCode, modelFlashing, modelFrames);
      if (flashTrig) begin
        modelFlashing = 1'b1;
        modelFrames   = 0;
      end else if (modelFlashing && frameStart) begin
        modelFrames++;
        if (modelFrames == FLASH_FRAMES) begin
          modelFlashing = 1'b0;
          modelFrames   = 0;
        end
      end
      expBusy = modelFlashing;
    end
  end

  always @(posedge clock) begin
    #1;
    if (resetN) begin
      checkOutput("modelValid", {7'd0, pixValidOut}, {7'd0, expValid});
      checkOutput("modelCode", {2'd0, colorCode}, {2'd0, expCode});
      checkOutput("modelBusy", {7'd0, flashBusy}, {7'd0, expBusy});
    end
  end

  task automatic applyStimulus(input logic pv, input logic [3:0] req, input logic fs, input logic trig);
    @(negedge clock);
    pixValid   = pv;
    layerReq   = req;
    frameStart = fs;
    flashTrig  = trig;
    @(posedge clock);
    #1;
  endtask

  task automatic runFrames(input int n);
    for (int f = 0; f < n; f++) begin
      applyStimulus(1'b1, 4'b0001, 1'b1, 1'b0);
      applyStimulus(1'b1, 4'b0001, 1'b0, 1'b0);
    end
  endtask

  initial begin
    // Random inputs while held in reset must not disturb the outputs.
    repeat (5) begin
      @(negedge clock);
      pixValid   = 1'($urandom);
      layerReq   = 4'($urandom);
      layerCode  = 24'($urandom);
      bgCode     = 6'($urandom);
      frameStart = 1'($urandom);
      flashTrig  = 1'($urandom);
      @(posedge clock);
      #1;
      checkOutput("resetCode", {2'd0, colorCode}, 8'd1);
      checkOutput("resetValid", {7'd0, pixValidOut}, 8'd0);
      checkOutput("resetBusy", {7'd0, flashBusy}, 8'd0);
    end
    @(negedge clock);
    resetN    = 1'b1;
    flashTrig = 1'b0;
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0);
    checkOutput("postResetCode", {2'd0, colorCode}, 8'd1);
    checkOutput("postResetBusy", {7'd0, flashBusy}, 8'd0);

    layerCode = {6'd7, 6'd8, 6'd2, 6'd9};
    bgCode    = 6'd4;
    applyStimulus(1'b1, 4'b0110, 1'b0, 1'b0);
    checkOutput("prioL1", {2'd0, colorCode}, 8'd2);
    checkOutput("prioValid", {7'd0, pixValidOut}, 8'd1);
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
    checkOutput("prioBg", {2'd0, colorCode}, 8'd4);
    applyStimulus(1'b0, 4'b0110, 1'b0, 1'b0);
    checkOutput("prioInvalid", {2'd0, colorCode}, 8'd1);
    applyStimulus(1'b1, 4'b1111, 1'b0, 1'b0);
    checkOutput("prioL0", {2'd0, colorCode}, 8'd9);
    applyStimulus(1'b1, 4'b1000, 1'b0, 1'b0);
    checkOutput("prioL3", {2'd0, colorCode}, 8'd7);
    bgCode = 6'd45;
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
    checkOutput("bgAbove10", {2'd0, colorCode}, 8'd45);

    layerCode = {6'd7, 6'd8, 6'd2, 6'd5};
    bgCode    = 6'd4;
    applyStimulus(1'b1, 4'b0001, 1'b0, 1'b1);
    checkOutput("trigCycleCode", {2'd0, colorCode}, 8'd5);
    checkOutput("trigCycleBusy", {7'd0, flashBusy}, 8'd1);
    applyStimulus(1'b1, 4'b0001, 1'b0, 1'b0);
    checkOutput("flashRed", {2'd0, colorCode}, 8'd3);
    applyStimulus(1'b1, 4'b0010, 1'b0, 1'b0);
    checkOutput("flashOtherLayer", {2'd0, colorCode}, 8'd2);
    runFrames(4);
    checkOutput("flashWhite", {2'd0, colorCode}, 8'd0);
    runFrames(25);
    checkOutput("flashBusy29", {7'd0, flashBusy}, 8'd1);
    runFrames(1);
    checkOutput("flashDone", {7'd0, flashBusy}, 8'd0);
    checkOutput("flashDoneCode", {2'd0, colorCode}, 8'd5);

    applyStimulus(1'b1, 4'b0001, 1'b0, 1'b1);
    runFrames(6);
    checkOutput("retrigWhite", {2'd0, colorCode}, 8'd0);
    applyStimulus(1'b1, 4'b0001, 1'b1, 1'b1);
    applyStimulus(1'b1, 4'b0001, 1'b0, 1'b0);
    checkOutput("retrigRed", {2'd0, colorCode}, 8'd3);
    runFrames(29);
    checkOutput("retrigBusy29", {7'd0, flashBusy}, 8'd1);
    runFrames(1);
    checkOutput("retrigDone", {7'd0, flashBusy}, 8'd0);

    applyStimulus(1'b1, 4'b0001, 1'b1, 1'b1);
    checkOutput("simulBusy", {7'd0, flashBusy}, 8'd1);
    runFrames(29);
    checkOutput("simulBusy29", {7'd0, flashBusy}, 8'd1);
    runFrames(1);
    checkOutput("simulDone", {7'd0, flashBusy}, 8'd0);

    applyStimulus(1'b1, 4'b0001, 1'b0, 1'b1);
    runFrames(2);
    @(negedge clock);
    resetN = 1'b0;
    #1;
    checkOutput("asyncBusy", {7'd0, flashBusy}, 8'd0);
    checkOutput("asyncCode", {2'd0, colorCode}, 8'd1);
    checkOutput("asyncValid", {7'd0, pixValidOut}, 8'd0);
    @(negedge clock);
    resetN = 1'b1;
    applyStimulus(1'b1, 4'b0001, 1'b0, 1'b0);
    checkOutput("afterResetCode", {2'd0, colorCode}, 8'd5);
    checkOutput("afterResetBusy", {7'd0, flashBusy}, 8'd0);

    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/color_layer_arbiter.md
Name: color_layer_arbiter

Overview:
- Per-pixel priority arbiter that decides which sprite layer (frog, cars, logs, river/road) drives the 6-bit colour code into color_mapper.
- Registers the winning code, one cycle of latency, aligned with a pixel-valid strobe.
- Contains a frame-counted "hit flash" sequencer that overrides the top-priority layer with alternating red/white for a fixed number of frames.
- Sits between the sprite/background generators and color_mapper in the VGA pixel path.

Parameters:
- NUM_LAYERS, 4, number of sprite layers; layer 0 has highest priority.
- FLASH_FRAMES, 30, frames the flash lasts after a trigger.
- FLASH_PERIOD, 4, frames per red/white phase during the flash.

Ports:
- Clk  in  1  pixel clock
- Reset_n  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse at the start of each frame (vsync edge)
- pix_valid  in  1  current pixel is inside the visible area
- layer_req  in  NUM_LAYERS  per-layer "pixel is opaque" flags
- layer_code  in  NUM_LAYERS*6  packed codes; layer i occupies bits [6i+5:6i]
- bg_code  in  6  background code used when no layer requests
- flash_trig  in  1  one-cycle pulse that starts or restarts the flash
- pix_valid_out  out  1  pix_valid delayed by 1 cycle
- colorcode  out  6  code to color_mapper
- flash_busy  out  1  high while the flash FSM is not IDLE

Behaviour:
- Reset values (asynchronous, Reset_n low):
  - pix_valid_out=0, colorcode=6'd1 (BLACK), flash_busy=0.
  - FSM=IDLE, frame_cnt=0, phase=0.
- Latency: inputs sampled at cycle N produce colorcode/pix_valid_out at N+1. Throughput is one pixel per clock, with no stalls.
- Selection (combinational, registered at the output):
  - pix_valid=0: code=BLACK (1).
  - Otherwise: the lowest index i with layer_req[i]=1 wins, and code=layer_code[i].
  - No request: code=bg_code.
  - Any code above 10 passes through unchanged; color_mapper handles it.
- Flash override: in FLASH, pix_valid=1 and layer_req[0]=1 forces code to RED (3) when phase=0 and WHITE (0) when phase=1. All other pixels are unaffected.
- FSM states and transitions:
  - IDLE: flash_trig goes to FLASH with frame_cnt=0, phase=0.
  - FLASH, on frame_start:
    - frame_cnt increments.
    - phase toggles when (frame_cnt+1) mod FLASH_PERIOD == 0.
    - When frame_cnt+1 == FLASH_FRAMES, go to IDLE and clear frame_cnt and phase.
  - FLASH, flash_trig (retrigger): frame_cnt=0, phase=0, stay in FLASH. Retrigger takes precedence over a simultaneous frame_start.
  - IDLE with flash_trig and frame_start in the same cycle: enter FLASH; that frame_start is not counted.
- flash_busy is registered and equals (state==FLASH). It is high the cycle after the trigger and low the cycle after the last counted frame_start.
- frame_cnt width is $clog2(FLASH_FRAMES+1) and never wraps, because it is bounded by the exit condition.
- Reset mid-flash returns immediately to IDLE/BLACK. No state survives the reset.

Optional Feature:
- Macro: COLOR_ARB_LAYER_MASK_EN.
- With the macro defined:
  - Adds inputs cfg_we (1) and cfg_mask (NUM_LAYERS).
  - A layer_en register (reset to all ones) loads cfg_mask on cfg_we; the new value is effective from the next cycle.
  - Arbitration uses layer_req & layer_en.
  - Flash override uses layer_req[0] & layer_en[0].
- Without the macro: the ports and register are absent, and all layers are always enabled.

Decomposition:
- Package color_pkg:
  - CODE_W=6.
  - Named colour-code constants: WHITE=0, BLACK=1, GREEN=2, RED=3, LIGHT_BLUE=4, YELLOW=5, GREY=6, ORANGE=7, BROWN=8, PURPLE=9, DARK_BLUE=10.
  - Flash FSM state enum {IDLE, FLASH}.
- One sub-module, layer_priority_sel: combinational fixed-priority select over NUM_LAYERS. Outputs a hit flag and the selected code. Instantiated once.

Test Plan:
- Reset: hold Reset_n=0 with random inputs -> colorcode=1, pix_valid_out=0, flash_busy=0. Release Reset_n -> same values until the first valid pixel.
- Priority: pix_valid=1, layer_req=4'b0110, codes {L1=2, L2=8}, bg_code=4 -> next cycle colorcode=2. Then layer_req=0 -> colorcode=4. Then pix_valid=0 -> colorcode=1.
- Flash timing (FLASH_FRAMES=30, FLASH_PERIOD=4): pulse flash_trig, layer_req[0]=1 with code 5. Required response:
  - Frames 0-3 -> 3.
  - Frames 4-7 -> 0.
  - After the 30th frame_start -> flash_busy drops and colorcode=5.
- Retrigger: flash_trig after 10 frames -> phase back to RED. flash_busy stays high for 30 more frame_starts.
- Simultaneous events: flash_trig and frame_start in the same cycle from IDLE -> the flash lasts exactly 30 further frame_starts. Reset_n pulsed mid-flash -> flash_busy=0 immediately (asynchronous).
- With COLOR_ARB_LAYER_MASK_EN: cfg_mask=4'b1110, layer_req=4'b0011 -> the layer 1 code wins. Flash has no effect on that pixel.
